// File: rtl/universal_add_sub_if.sv
// universal_add_sub_if: valid-qualified operand stream and registered result bus for universal_add_sub.
// Overflow is carried only when UAS_OVERFLOW_EN is defined.
interface universal_add_sub_if #(parameter int WIDTH = 4);
   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             M;
   logic             out_valid;
   logic [WIDTH-1:0] Result;
   logic             Cout;
`ifdef UAS_OVERFLOW_EN
   logic             Overflow;
   modport master (output in_valid, A, B, M, input out_valid, Result, Cout, Overflow);
   modport slave  (input in_valid, A, B, M, output out_valid, Result, Cout, Overflow);
`else
   modport master (output in_valid, A, B, M, input out_valid, Result, Cout);
   modport slave  (input in_valid, A, B, M, output out_valid, Result, Cout);
`endif
endinterface

// File: rtl/universal_add_sub.sv
// universal_add_sub: registered ripple-carry adder/subtractor, M=0 add, M=1 subtract, one-cycle latency.
// Optional signed overflow output enabled by defining UAS_OVERFLOW_EN.
module universal_add_sub #(parameter int WIDTH = 4) (
   input logic clk,
   input logic rst_n,
   universal_add_sub_if.slave bus
);
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;
   assign c[0] = bus.M;
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      logic bx;
      assign bx       = bus.B[i] ^ bus.M;
      assign s[i]     = bus.A[i] ^ bx ^ c[i];
      assign c[i+1]   = (bus.A[i] & bx) | (c[i] & (bus.A[i] ^ bx));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.Result    <= '0;
         bus.Cout      <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.Result <= s;
            bus.Cout   <= c[WIDTH];
         end
      end
   end
`ifdef UAS_OVERFLOW_EN
   // signed overflow: carry into MSB disagrees with carry out of MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.Overflow <= 1'b0;
      else if (bus.in_valid) bus.Overflow <= c[WIDTH] ^ c[WIDTH-1];
   end
`endif
endmodule

// File: tb/tb_universal_add_sub.sv
// tb_universal_add_sub: directed checks of reset, add, subtract, hold, streaming and mid-stream reset.
module tb_universal_add_sub;
   localparam int W = 4;
   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic       m;
      logic [3:0] r;
      logic       c;
      logic       o;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   vec_t v [6];
   universal_add_sub_if #(.WIDTH(W)) bus ();
   universal_add_sub #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic drive(input logic vl, input vec_t x);
      bus.in_valid = vl;
      bus.A = x.a;
      bus.B = x.b;
      bus.M = x.m;
   endtask

   task automatic test_reset;
      drive(1'b1, v[0]);
      @(negedge clk);
      tests++;
      if ({bus.out_valid, bus.Result, bus.Cout} !== 6'b0) begin
         fails++;
         $display("FAIL reset_hold got v=%b r=%b c=%b want 0/0000/0", bus.out_valid, bus.Result, bus.Cout);
      end
`ifdef UAS_OVERFLOW_EN
      tests++;
      if (bus.Overflow !== 1'b0) begin
         fails++;
         $display("FAIL reset_ovf got %b want 0", bus.Overflow);
      end
`endif
      drive(1'b0, v[0]);
      rst_n = 1'b1;
   endtask

   task automatic run_vec(input string name, input vec_t x);
      @(negedge clk);
      drive(1'b1, x);
      @(negedge clk);
      drive(1'b0, v[5]);
      tests++;
      if ({bus.out_valid, bus.Result, bus.Cout} !== {1'b1, x.r, x.c}) begin
         fails++;
         $display("FAIL %s got v=%b r=%b c=%b want v=1 r=%b c=%b", name, bus.out_valid, bus.Result, bus.Cout, x.r, x.c);
      end
`ifdef UAS_OVERFLOW_EN
      tests++;
      if (bus.Overflow !== x.o) begin
         fails++;
         $display("FAIL %s_ovf got %b want %b", name, bus.Overflow, x.o);
      end
`endif
   endtask

   task automatic test_add;
      run_vec("add_0101_0011", v[0]);
      run_vec("add_1100_0010", v[1]);
      run_vec("add_wrap_1111_0001", v[4]);
   endtask

   task automatic test_sub;
      run_vec("sub_1000_0011", v[2]);
      run_vec("sub_0000_0000", v[5]);
      run_vec("sub_borrow_0100_0101", v[3]);
   endtask

   task automatic test_hold;
      vec_t junk;
      junk = '{4'b1010, 4'b0110, 1'b0, 4'b0000, 1'b0, 1'b0};
      drive(1'b0, junk);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         tests++;
         if ({bus.out_valid, bus.Result, bus.Cout} !== {1'b0, 4'b1111, 1'b0}) begin
            fails++;
            $display("FAIL hold_%0d got v=%b r=%b c=%b want v=0 r=1111 c=0", k, bus.out_valid, bus.Result, bus.Cout);
         end
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      drive(1'b1, v[0]);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k < 3) drive(1'b1, v[k+1]);
         else drive(1'b0, v[1]);
         tests++;
         if ({bus.out_valid, bus.Result, bus.Cout} !== {1'b1, v[k].r, v[k].c}) begin
            fails++;
            $display("FAIL stream_%0d got v=%b r=%b c=%b want v=1 r=%b c=%b", k, bus.out_valid, bus.Result, bus.Cout, v[k].r, v[k].c);
         end
`ifdef UAS_OVERFLOW_EN
         tests++;
         if (bus.Overflow !== v[k].o) begin
            fails++;
            $display("FAIL stream_%0d_ovf got %b want %b", k, bus.Overflow, v[k].o);
         end
`endif
      end
      @(negedge clk);
      tests++;
      if ({bus.out_valid, bus.Result} !== {1'b0, 4'b1111}) begin
         fails++;
         $display("FAIL stream_idle got v=%b r=%b want v=0 r=1111", bus.out_valid, bus.Result);
      end
   endtask

   task automatic test_mid_reset;
      @(negedge clk);
      drive(1'b1, v[0]);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      drive(1'b1, v[1]);
      #1;
      tests++;
      if ({bus.out_valid, bus.Result, bus.Cout} !== 6'b0) begin
         fails++;
         $display("FAIL async_reset got v=%b r=%b c=%b want 0/0000/0", bus.out_valid, bus.Result, bus.Cout);
      end
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_discard got v=%b want 0", bus.out_valid);
      end
      rst_n = 1'b1;
      drive(1'b0, v[1]);
      @(negedge clk);
      tests++;
      if ({bus.out_valid, bus.Result} !== 5'b0) begin
         fails++;
         $display("FAIL post_reset_idle got v=%b r=%b want 0/0000", bus.out_valid, bus.Result);
      end
      run_vec("recover_add_1100_0010", v[1]);
   endtask

   initial begin
      v[0] = '{4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1};
      v[1] = '{4'b1100, 4'b0010, 1'b0, 4'b1110, 1'b0, 1'b0};
      v[2] = '{4'b1000, 4'b0011, 1'b1, 4'b0101, 1'b1, 1'b1};
      v[3] = '{4'b0100, 4'b0101, 1'b1, 4'b1111, 1'b0, 1'b0};
      v[4] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
      v[5] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
      test_reset;
      test_add;
      test_sub;
      test_hold;
      test_back_to_back;
      test_mid_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
